// File: rtl/n_clic_seq_pkg.sv
// Shared types for the CLIC interrupt entry/exit sequencer.
package n_clic_seq_pkg;

    localparam int NR_IRQ      = 8;
    localparam int PRIO_BITS   = 3;
    localparam int STACK_DEPTH = 4;
    localparam int ID_W        = $clog2(NR_IRQ);
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    typedef logic [31:0]          word_t;
    typedef logic [PRIO_BITS-1:0] prio_t;
    typedef logic [ID_W-1:0]      irq_id_t;

    typedef struct packed {
        word_t pc;
        prio_t level;
    } stack_entry_t;

    typedef enum logic [1:0] {IDLE, TAKE, RET} seq_state_t;

    // Vector entry address; 32-bit modulo, wrap-around is intentional.
    function automatic word_t vec_entry(word_t base, irq_id_t id);
        return base + {{(32-ID_W-2){1'b0}}, id, 2'b00};
    endfunction

endpackage

// File: rtl/n_clic_stack.sv
// LIFO of saved {pc, level} entries; push and pop are never asserted together.
module n_clic_stack
    import n_clic_seq_pkg::*;
#(
    parameter  int Depth  = STACK_DEPTH,
    localparam int DepthW = $clog2(Depth + 1),
    localparam int AddrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  stack_entry_t      din,
    output stack_entry_t      dout,
    output logic [DepthW-1:0] depth
);

    stack_entry_t     mem [Depth];
    logic [AddrW-1:0] rd_idx;
    logic [AddrW-1:0] wr_idx;

    assign rd_idx = AddrW'(depth - 1'b1);
    assign wr_idx = AddrW'(depth);
    assign dout   = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset)
            depth <= '0;
        else if (push)
            depth <= depth + 1'b1;
        else if (pop)
            depth <= depth - 1'b1;
    end

    // Contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_idx] <= din;
    end

endmodule

// File: rtl/n_clic_seq.sv
// Interrupt entry/exit sequencer: preempts at instruction boundaries, stacks
// the return pc and preempted level, and unwinds on mret.
module n_clic_seq
    import n_clic_seq_pkg::*;
#(
    parameter  int          NrIrq      = NR_IRQ,
    parameter  int          PrioBits   = PRIO_BITS,
    parameter  int          StackDepth = STACK_DEPTH,
    parameter  logic [31:0] VecBase    = 32'h0000_0100,
    localparam int          IdW        = $clog2(NrIrq),
    localparam int          DepthW     = $clog2(StackDepth + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                irq_valid,
    input  logic [IdW-1:0]      irq_id,
    input  logic [PrioBits-1:0] irq_prio,
    output logic                irq_ack,
    output logic [IdW-1:0]      irq_id_ack,
    input  logic                instr_boundary,
    input  logic [31:0]         pc_next,
    input  logic                mret,
    output logic                pc_redirect,
    output logic [31:0]         pc_target,
    output logic [PrioBits-1:0] level,
    output logic [DepthW-1:0]   depth,
    output logic                underflow_err
);

    localparam logic [DepthW-1:0] FULL = DepthW'(StackDepth);

    seq_state_t   state;
    stack_entry_t stk_din;
    stack_entry_t stk_dout;
    logic         mret_idle;
    logic         take;
    logic         do_push;
    logic         do_pop;

    // prio>0 is implied by prio>level since level is never negative.
    assign take      = (state == IDLE) && instr_boundary && irq_valid &&
                       (irq_prio > level) && (depth < FULL);
    assign mret_idle = (state == IDLE) && mret;
    assign do_pop    = mret_idle && (depth != '0);
    assign do_push   = take && !mret_idle;
    assign stk_din   = '{pc: pc_next, level: level};

    n_clic_stack #(.Depth(StackDepth)) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .depth (depth)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            level         <= '0;
            irq_ack       <= 1'b0;
            irq_id_ack    <= '0;
            pc_redirect   <= 1'b0;
            pc_target     <= '0;
            underflow_err <= 1'b0;
        end else begin
            irq_ack     <= 1'b0;
            irq_id_ack  <= '0;
            pc_redirect <= 1'b0;
            case (state)
                IDLE: begin
                    // mret always claims the cycle, so a pending irq waits for the next IDLE.
                    if (mret_idle) begin
                        if (do_pop) begin
                            state       <= RET;
                            level       <= stk_dout.level;
                            pc_redirect <= 1'b1;
                            pc_target   <= stk_dout.pc;
                        end else begin
                            underflow_err <= 1'b1;
                        end
                    end else if (do_push) begin
                        state       <= TAKE;
                        level       <= irq_prio;
                        irq_ack     <= 1'b1;
                        irq_id_ack  <= irq_id;
                        pc_redirect <= 1'b1;
                        pc_target   <= vec_entry(VecBase, irq_id);
                    end
                end
                TAKE:    state <= IDLE;
                RET:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n_clic_seq.sv
// Scoreboard bench: stimulus queues expected redirect events, a monitor checks them.
module tb_n_clic_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_valid;
    logic [2:0]  irq_id;
    logic [2:0]  irq_prio;
    logic        irq_ack;
    logic [2:0]  irq_id_ack;
    logic        instr_boundary;
    logic [31:0] pc_next;
    logic        mret;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [2:0]  level;
    logic [2:0]  depth;
    logic        underflow_err;

    typedef struct {
        logic        ack;
        logic [2:0]  id;
        logic [31:0] tgt;
        logic [2:0]  lvl;
        logic [2:0]  dep;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    n_clic_seq dut (
        .clk            (clk),
        .reset          (reset),
        .irq_valid      (irq_valid),
        .irq_id         (irq_id),
        .irq_prio       (irq_prio),
        .irq_ack        (irq_ack),
        .irq_id_ack     (irq_id_ack),
        .instr_boundary (instr_boundary),
        .pc_next        (pc_next),
        .mret           (mret),
        .pc_redirect    (pc_redirect),
        .pc_target      (pc_target),
        .level          (level),
        .depth          (depth),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Monitor: every redirect/ack event must match the next queued expectation.
    always @(negedge clk) begin
        if (irq_ack || pc_redirect) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got ack=%0b redirect=%0b target='h%0h, expected no event",
                         irq_ack, pc_redirect, pc_target);
            end else begin
                e = q.pop_front();
                chk("ack",      32'(irq_ack),     32'(e.ack));
                chk("redirect", 32'(pc_redirect), 32'd1);
                chk("id_ack",   32'(irq_id_ack),  e.ack ? 32'(e.id) : 32'd0);
                chk("target",   pc_target,        e.tgt);
                chk("level",    32'(level),       32'(e.lvl));
                chk("depth",    32'(depth),       32'(e.dep));
            end
        end
    end

    task automatic cyc(input logic v, input logic [2:0] id, input logic [2:0] pr,
                       input logic bnd, input logic [31:0] pc, input logic m);
        irq_valid      = v;
        irq_id         = id;
        irq_prio       = pr;
        instr_boundary = bnd;
        pc_next        = pc;
        mret           = m;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 3'd0, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic exp_take(input logic [2:0] id, input logic [31:0] tgt,
                            input logic [2:0] lvl, input logic [2:0] dep);
        q.push_back('{ack: 1'b1, id: id, tgt: tgt, lvl: lvl, dep: dep});
    endtask

    task automatic exp_ret(input logic [31:0] tgt, input logic [2:0] lvl, input logic [2:0] dep);
        q.push_back('{ack: 1'b0, id: 3'd0, tgt: tgt, lvl: lvl, dep: dep});
    endtask

    initial begin
        reset = 1'b1;
        irq_valid = 1'b0; irq_id = '0; irq_prio = '0;
        instr_boundary = 1'b0; pc_next = '0; mret = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level",     32'(level),         32'd0);
        chk("rst_depth",     32'(depth),         32'd0);
        chk("rst_ack",       32'(irq_ack),       32'd0);
        chk("rst_redirect",  32'(pc_redirect),   32'd0);
        chk("rst_target",    pc_target,          32'd0);
        chk("rst_underflow", 32'(underflow_err), 32'd0);
        reset = 1'b0;
        idle();

        // Basic take from thread mode.
        exp_take(3'd3, 32'h10C, 3'd2, 3'd1);
        cyc(1'b1, 3'd3, 3'd2, 1'b1, 32'h40, 1'b0);
        idle();

        // Equal priority holds off; higher priority nests.
        cyc(1'b1, 3'd5, 3'd2, 1'b1, 32'h100, 1'b0);
        cyc(1'b1, 3'd5, 3'd2, 1'b1, 32'h100, 1'b0);
        chk("eq_prio_depth", 32'(depth), 32'd1);
        exp_take(3'd5, 32'h114, 3'd4, 3'd2);
        cyc(1'b1, 3'd5, 3'd4, 1'b1, 32'h110, 1'b0);
        idle();

        // No boundary: no take even though the irq outranks the level.
        cyc(1'b1, 3'd6, 3'd7, 1'b0, 32'h120, 1'b0);
        chk("no_bnd_level", 32'(level), 32'd4);

        // Unwind both levels.
        exp_ret(32'h110, 3'd2, 3'd1);
        cyc(1'b0, 3'd0, 3'd0, 1'b1, 32'h0, 1'b1);
        idle();
        exp_ret(32'h40, 3'd0, 3'd0);
        cyc(1'b0, 3'd0, 3'd0, 1'b1, 32'h0, 1'b1);
        idle();

        // Prio 0 never taken.
        cyc(1'b1, 3'd2, 3'd0, 1'b1, 32'h80, 1'b0);
        chk("prio0_depth", 32'(depth), 32'd0);

        // Fill the stack with rising priority.
        exp_take(3'd1, 32'h104, 3'd1, 3'd1); cyc(1'b1, 3'd1, 3'd1, 1'b1, 32'h200, 1'b0); idle();
        exp_take(3'd2, 32'h108, 3'd2, 3'd2); cyc(1'b1, 3'd2, 3'd2, 1'b1, 32'h204, 1'b0); idle();
        exp_take(3'd4, 32'h110, 3'd3, 3'd3); cyc(1'b1, 3'd4, 3'd3, 1'b1, 32'h208, 1'b0); idle();
        exp_take(3'd6, 32'h118, 3'd4, 3'd4); cyc(1'b1, 3'd6, 3'd4, 1'b1, 32'h20C, 1'b0); idle();

        // Full: prio 7 must wait.
        repeat (3) cyc(1'b1, 3'd7, 3'd7, 1'b1, 32'h2F0, 1'b0);
        chk("full_depth", 32'(depth), 32'd4);
        chk("full_level", 32'(level), 32'd4);

        // mret with eligible irq in the same cycle: RET first, ignored in RET, taken in next IDLE.
        exp_ret(32'h20C, 3'd3, 3'd3);
        cyc(1'b1, 3'd7, 3'd7, 1'b1, 32'h2F0, 1'b1);
        cyc(1'b1, 3'd7, 3'd7, 1'b1, 32'h2F4, 1'b0);
        exp_take(3'd7, 32'h11C, 3'd7, 3'd4);
        cyc(1'b1, 3'd7, 3'd7, 1'b1, 32'h300, 1'b0);
        idle();

        // Unwind everything; saved levels come back in order.
        exp_ret(32'h300, 3'd3, 3'd3); cyc(1'b0, 3'd0, 3'd0, 1'b1, 32'h0, 1'b1); idle();
        exp_ret(32'h208, 3'd2, 3'd2); cyc(1'b0, 3'd0, 3'd0, 1'b1, 32'h0, 1'b1); idle();
        exp_ret(32'h204, 3'd1, 3'd1); cyc(1'b0, 3'd0, 3'd0, 1'b1, 32'h0, 1'b1); idle();
        exp_ret(32'h200, 3'd0, 3'd0); cyc(1'b0, 3'd0, 3'd0, 1'b1, 32'h0, 1'b1); idle();

        // mret at depth 0: sticky error, nothing else changes.
        chk("pre_underflow", 32'(underflow_err), 32'd0);
        cyc(1'b0, 3'd0, 3'd0, 1'b1, 32'h0, 1'b1);
        chk("underflow",       32'(underflow_err), 32'd1);
        chk("underflow_depth", 32'(depth),         32'd0);
        chk("underflow_level", 32'(level),         32'd0);
        idle();
        idle();
        chk("underflow_sticky", 32'(underflow_err), 32'd1);

        // Reset during TAKE: no pulse afterwards, stack discarded.
        exp_take(3'd2, 32'h108, 3'd5, 3'd1);
        cyc(1'b1, 3'd2, 3'd5, 1'b1, 32'h50, 1'b0);
        reset = 1'b1;
        idle();
        chk("rst_take_redirect",  32'(pc_redirect),   32'd0);
        chk("rst_take_ack",       32'(irq_ack),       32'd0);
        chk("rst_take_depth",     32'(depth),         32'd0);
        chk("rst_take_level",     32'(level),         32'd0);
        chk("rst_take_underflow", 32'(underflow_err), 32'd0);
        reset = 1'b0;

        // Fresh take after reset lands at depth 1.
        exp_take(3'd0, 32'h100, 3'd1, 3'd1);
        cyc(1'b1, 3'd0, 3'd1, 1'b1, 32'h60, 1'b0);
        idle();
        idle();

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
